// File: rtl/sample_pkg.sv
// Shared definitions for the sample loader: FSM encoding and checksum width.
package sample_pkg;

   localparam int unsigned CHECKSUM_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : sample_pkg

// File: rtl/load_index_counter.sv
// Sample index counter: synchronous clear, count enable, terminal count at
// sampling_frequency-1.
module load_index_counter #(
   parameter int unsigned addr_width         = 7,
   parameter int unsigned sampling_frequency = 100
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  en_i,
   output logic [addr_width-1:0] count_o,
   output logic                  tc_o
);

   localparam logic [addr_width-1:0] LAST_IDX = addr_width'(sampling_frequency - 1);

   logic [addr_width-1:0] count_q;
   logic [addr_width-1:0] count_d;

   // Next count: clear wins over increment.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + addr_width'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == LAST_IDX);

endmodule : load_index_counter

// File: rtl/sample_loader.sv
// Streams one table of samples from a valid/ready source into sample memory.
// Optional running checksum enabled by defining LOADER_CHECKSUM_EN; without it
// the checksum port is tied to zero.
module sample_loader
   import sample_pkg::*;
#(
   parameter int unsigned addr_width         = 7,
   parameter int unsigned data_width         = 8,
   parameter int unsigned sampling_frequency = 100
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [data_width-1:0] s_data,
   output logic                  s_ready,
   output logic                  wr_en,
   output logic [addr_width-1:0] wr_addr,
   output logic [data_width-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic [CHECKSUM_W-1:0] checksum
);

   state_e                state_q, state_d;
   logic                  wr_en_q, wr_en_d;
   logic [addr_width-1:0] wr_addr_q, wr_addr_d;
   logic [data_width-1:0] wr_data_q, wr_data_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  accept;
   logic                  clear;
   logic [addr_width-1:0] idx;
   logic                  idx_tc;

   // Source handshake: abort blocks acceptance in the same cycle.
   assign s_ready = (state_q == ST_LOAD) && !abort;
   assign accept  = s_valid && s_ready;

   load_index_counter #(
      .addr_width        (addr_width),
      .sampling_frequency(sampling_frequency)
   ) u_index (
      .clk_i  (Clk),
      .rst_i  (Rst),
      .clear_i(clear),
      .en_i   (accept),
      .count_o(idx),
      .tc_o   (idx_tc)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      clear     = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      busy_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               clear   = 1'b1;
            end
         end
         ST_LOAD: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (accept && idx_tc) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (accept) begin
         wr_en_d   = 1'b1;
         wr_addr_d = idx;
         wr_data_d = s_data;
         done_d    = idx_tc;
      end

      busy_d = (state_d == ST_LOAD);
   end

   // State and output registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q   <= ST_IDLE;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = busy_q;
   assign done    = done_q;

`ifdef LOADER_CHECKSUM_EN
   logic [CHECKSUM_W-1:0] csum_q, csum_d;

   // Running sum of accepted samples, restarted with each load.
   always_comb begin
      csum_d = csum_q;
      if (clear) begin
         csum_d = '0;
      end else if (accept) begin
         csum_d = csum_q + CHECKSUM_W'(s_data);
      end
   end

   // Checksum register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

endmodule : sample_loader

// File: tb/tb_sample_loader.sv
// Scoreboard bench for sample_loader: driver predicts writes into a queue,
// negedge monitor pops and compares whenever wr_en is seen.
module tb_sample_loader;

   localparam int AW = 7;
   localparam int DW = 8;
   localparam int SF = 100;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic [15:0]   checksum;

   sample_loader #(
      .addr_width(AW), .data_width(DW), .sampling_frequency(SF)
   ) dut (
      .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          last;
      logic [15:0]   cs;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   m_done_exp = 0;

   // Reference model: phase 0 idle, 1 loading, 2 table complete.
   int   m_phase = 0;
   int   m_idx = 0;
   int   m_sum = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: each write must match the oldest predicted write.
   exp_t me;
   always @(negedge Clk) begin
      if (!Rst) begin
         if (wr_en) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write addr=%0d data=%0h expected=none t=%0t",
                        wr_addr, wr_data, $time);
            end else begin
               me = q.pop_front();
               chk("wr_addr", 32'(wr_addr), 32'(me.a));
               chk("wr_data", 32'(wr_data), 32'(me.d));
               chk("done_on_write", 32'(done), 32'(me.last));
               chk("checksum", 32'(checksum), 32'(me.cs));
               if (done) n_done++;
            end
         end else begin
            chk("done_idle", 32'(done), 32'h0);
         end
      end
   end

   // One cycle of stimulus; predicts acceptance and the resulting phase.
   task automatic step(input logic st, input logic ab, input logic v, input logic [DW-1:0] d);
      exp_t e;
      bit   acc;
      @(posedge Clk);
      #1;
      chk("busy", 32'(busy), 32'(m_phase == 1));
      start = st; abort = ab; s_valid = v; s_data = d;
      #1;
      chk("s_ready", 32'(s_ready), 32'(m_phase == 1 && !ab));
      acc = (m_phase == 1) && v && !ab;
      if (acc) begin
         e.a    = AW'(m_idx);
         e.d    = d;
         e.last = (m_idx == SF - 1);
`ifdef LOADER_CHECKSUM_EN
         m_sum  = (m_sum + int'(d)) % 65536;
         e.cs   = 16'(m_sum);
`else
         e.cs   = 16'h0;
`endif
         q.push_back(e);
         m_idx++;
         if (e.last) m_done_exp++;
      end
      case (m_phase)
         0: if (st) begin m_phase = 1; m_idx = 0; m_sum = 0; end
         1: if (ab) m_phase = 0; else if (acc && m_idx == SF) m_phase = 2;
         default: m_phase = 0;
      endcase
   endtask

   // Start (retrying until accepted) and feed one table.
   // mode 0: data=index, 1: all 0xFF, 2: random data, valid toggling,
   // 3: random data and valid.
   task automatic run_load(input bit hold, input int mode, input int abort_at);
      int guard;
      bit v, ab;
      logic [DW-1:0] d;
      guard = 0;
      while (m_phase != 1 && guard < 10) begin
         step(1'b1, 1'b0, 1'b0, '0);
         guard++;
      end
      guard = 0;
      while (m_phase == 1 && guard < 2000) begin
         case (mode)
            0: begin v = 1'b1; d = DW'(m_idx); end
            1: begin v = 1'b1; d = 8'hFF; end
            2: begin v = (guard % 2 == 0); d = DW'($urandom); end
            default: begin v = ($urandom_range(0, 2) != 0); d = DW'($urandom); end
         endcase
         ab = (abort_at >= 0) && (m_idx == abort_at) && v;
         step(hold, ab, v, d);
         guard++;
      end
      if (guard >= 2000) begin
         checks++;
         errors++;
         $display("FAIL load_timeout actual=%0d expected=<2000 cycles", guard);
      end
   endtask

   initial begin
      #12;
      chk("rst_wr_en", 32'(wr_en), 32'h0);
      chk("rst_wr_addr", 32'(wr_addr), 32'h0);
      chk("rst_wr_data", 32'(wr_data), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_checksum", 32'(checksum), 32'h0);
      @(posedge Clk);
      #1 Rst = 1'b0;

      // Full back-to-back load of 0..99.
      run_load(1'b0, 0, -1);
      repeat (3) step(1'b0, 1'b0, 1'b1, 8'h55);

      // Stalled source.
      run_load(1'b0, 2, -1);
      repeat (2) step(1'b0, 1'b0, 1'b0, '0);

      // Abort at index 40 with valid high, then reload from 0.
      run_load(1'b0, 3, 40);
      repeat (2) step(1'b0, 1'b0, 1'b1, 8'hAA);
      run_load(1'b0, 0, -1);
      repeat (2) step(1'b0, 1'b0, 1'b0, '0);

      // All 0xFF: checksum 0x639C with the feature, 0 without.
      run_load(1'b0, 1, -1);
      step(1'b0, 1'b0, 1'b0, '0);
`ifdef LOADER_CHECKSUM_EN
      chk("checksum_final", 32'(checksum), 32'h639C);
`else
      chk("checksum_final", 32'(checksum), 32'h0);
`endif

      // start held through DONE: one IDLE cycle, then a fresh load.
      run_load(1'b1, 3, -1);
      run_load(1'b1, 0, -1);
      repeat (2) step(1'b0, 1'b0, 1'b0, '0);

      // Reset at index 10 with a write pending.
      step(1'b1, 1'b0, 1'b0, '0);
      while (m_idx < 11) step(1'b0, 1'b0, 1'b1, DW'($urandom));
      @(posedge Clk);
      #1 Rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
      chk("mid_rst_wr_addr", 32'(wr_addr), 32'h0);
      chk("mid_rst_wr_data", 32'(wr_data), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_checksum", 32'(checksum), 32'h0);
      q.delete();
      m_phase = 0;
      start = 1'b0; abort = 1'b0; s_valid = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      repeat (6) step(1'b0, 1'b0, 1'b1, DW'($urandom));
      run_load(1'b0, 3, -1);
      repeat (3) step(1'b0, 1'b0, 1'b0, '0);

      chk("pending_writes", 32'(q.size()), 32'h0);
      chk("done_count", 32'(n_done), 32'(m_done_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sample_loader
